// File: rtl/cntr_n.sv
// Up/down counter with parallel load, driven by a small direction-tracking FSM.
// Wraps or saturates depending on SAT; ovf pulses on any carry, borrow or clamp.
module cntr_n #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic [2:0]       o_state,
   output logic             ovf
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b000,
      ST_LOAD = 3'b001,
      ST_INC  = 3'b010,
      ST_INC2 = 3'b011,
      ST_DEC  = 3'b100,
      ST_DEC2 = 3'b101
   } state_e;

   localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH-1:0] MAX_V  = '1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   sum, diff;
   logic             legal;

   // One extra bit on each side exposes the carry/borrow directly.
   always_comb begin
      sum  = {1'b0, d_out_q} + STEP_X;
      diff = {1'b0, d_out_q} - STEP_X;
   end

   always_comb begin
      state_d = ST_IDLE;
      d_out_d = d_out_q;
      ovf_d   = 1'b0;
      legal   = state_q inside {ST_IDLE, ST_LOAD, ST_INC, ST_INC2, ST_DEC, ST_DEC2};
      // A corrupted state code recovers to IDLE with d_out held, ignoring inputs.
      if (legal) begin
         if (load) begin
            state_d = ST_LOAD;
            d_out_d = d_in;
         end else if (!en) begin
            state_d = ST_IDLE;
         end else if (inc) begin
            state_d = (state_q == ST_INC) ? ST_INC2 : ST_INC;
            d_out_d = sum[WIDTH-1:0];
            if (sum[WIDTH]) begin
               ovf_d = 1'b1;
               if (SAT) d_out_d = MAX_V;
            end
         end else begin
            state_d = (state_q == ST_DEC) ? ST_DEC2 : ST_DEC;
            d_out_d = diff[WIDTH-1:0];
            if (diff[WIDTH]) begin
               ovf_d = 1'b1;
               if (SAT) d_out_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         d_out_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_out_q <= d_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign d_out   = d_out_q;
   assign o_state = state_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_cntr_n.sv
// Drives three cntr_n configurations (wrap, saturate, STEP=5) with shared stimulus
// and checks each against an integer-arithmetic reference model.
module tb_cntr_n;

   logic       clk = 1'b0;
   logic       reset, en, load, inc;
   logic [7:0] d_in;
   logic [7:0] dout_a  [3];
   logic [2:0] state_a [3];
   logic       ovf_a   [3];

   localparam int STEPS [3] = '{1, 1, 5};
   localparam int SATS  [3] = '{0, 1, 0};

   int m_val [3];
   int m_st  [3];
   int m_ovf [3];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cntr_n #(.WIDTH(8), .STEP(1), .SAT(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .en(en), .load(load), .inc(inc), .d_in(d_in),
      .d_out(dout_a[0]), .o_state(state_a[0]), .ovf(ovf_a[0]));
   cntr_n #(.WIDTH(8), .STEP(1), .SAT(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .load(load), .inc(inc), .d_in(d_in),
      .d_out(dout_a[1]), .o_state(state_a[1]), .ovf(ovf_a[1]));
   cntr_n #(.WIDTH(8), .STEP(5), .SAT(1'b0)) dut_step5 (
      .clk(clk), .reset(reset), .en(en), .load(load), .inc(inc), .d_in(d_in),
      .d_out(dout_a[2]), .o_state(state_a[2]), .ovf(ovf_a[2]));

   // Reference behaviour: exact integer result, then wrap or clamp if outside 0..255.
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         int exact;
         if (reset) begin
            m_val[k] = 0; m_st[k] = 0; m_ovf[k] = 0;
         end else if (load) begin
            m_val[k] = d_in; m_st[k] = 1; m_ovf[k] = 0;
         end else if (!en) begin
            m_st[k] = 0; m_ovf[k] = 0;
         end else begin
            exact = inc ? m_val[k] + STEPS[k] : m_val[k] - STEPS[k];
            if (inc) m_st[k] = (m_st[k] == 2) ? 3 : 2;
            else     m_st[k] = (m_st[k] == 4) ? 5 : 4;
            m_ovf[k] = (exact > 255 || exact < 0) ? 1 : 0;
            if (exact > 255)    m_val[k] = SATS[k] ? 255 : exact - 256;
            else if (exact < 0) m_val[k] = SATS[k] ? 0 : exact + 256;
            else                m_val[k] = exact;
         end
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic l, input logic i, input logic [7:0] d);
      reset = r; en = e; load = l; inc = i; d_in = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dout_a[k] !== 8'h00) begin errors++; $display("[TB] FAIL reset d_out dut%0d: got %h want 00", k, dout_a[k]); end
         checks++;
         if (state_a[k] !== 3'b000) begin errors++; $display("[TB] FAIL reset o_state dut%0d: got %b want 000", k, state_a[k]); end
         checks++;
         if (ovf_a[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset ovf dut%0d: got %b want 0", k, ovf_a[k]); end
      end
   endtask

   task automatic test_load_ff();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dout_a[k] !== 8'hFF || state_a[k] !== 3'b001 || ovf_a[k] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_ff dut%0d: got d=%h st=%b ovf=%b want d=ff st=001 ovf=0", k, dout_a[k], state_a[k], ovf_a[k]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_d  [3] = '{8'hFF, 8'h00, 8'h01};
      logic [2:0] exp_st [3] = '{3'b010, 3'b011, 3'b010};
      logic       exp_o  [3] = '{1'b0, 1'b1, 1'b0};
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
      for (int n = 0; n < 3; n++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
         checks++;
         if (dout_a[0] !== exp_d[n] || state_a[0] !== exp_st[n] || ovf_a[0] !== exp_o[n]) begin
            errors++;
            $display("[TB] FAIL wrap step%0d: got d=%h st=%b ovf=%b want d=%h st=%b ovf=%b",
                     n, dout_a[0], state_a[0], ovf_a[0], exp_d[n], exp_st[n], exp_o[n]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [2:0] exp_st [3] = '{3'b100, 3'b101, 3'b100};
      logic       exp_o  [3] = '{1'b0, 1'b1, 1'b1};
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
      for (int n = 0; n < 3; n++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         checks++;
         if (dout_a[1] !== 8'h00 || state_a[1] !== exp_st[n] || ovf_a[1] !== exp_o[n]) begin
            errors++;
            $display("[TB] FAIL sat_low step%0d: got d=%h st=%b ovf=%b want d=00 st=%b ovf=%b",
                     n, dout_a[1], state_a[1], ovf_a[1], exp_st[n], exp_o[n]);
         end
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (dout_a[1] !== 8'hFF || ovf_a[1] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_high: got d=%h ovf=%b want d=ff ovf=1", dout_a[1], ovf_a[1]);
      end
   endtask

   task automatic test_step5();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hFD);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (dout_a[2] !== 8'h02 || ovf_a[2] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL step5_wrap: got d=%h ovf=%b want d=02 ovf=1", dout_a[2], ovf_a[2]);
      end
   endtask

   task automatic test_load_priority();
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dout_a[k] !== 8'h40 || state_a[k] !== 3'b001 || ovf_a[k] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_prio dut%0d: got d=%h st=%b ovf=%b want d=40 st=001 ovf=0", k, dout_a[k], state_a[k], ovf_a[k]);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dout_a[k] !== 8'h40 || state_a[k] !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_hold dut%0d: got d=%h st=%b want d=40 st=000", k, dout_a[k], state_a[k]);
         end
      end
   endtask

   task automatic test_direction_change();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (dout_a[0] !== 8'h81 || state_a[0] !== 3'b100) begin
         errors++;
         $display("[TB] FAIL dir_change: got d=%h st=%b want d=81 st=100", dout_a[0], state_a[0]);
      end
   endtask

   task automatic test_reset_mid_count();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h35);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (dout_a[0] !== 8'h37 || state_a[0] !== 3'b011) begin
         errors++;
         $display("[TB] FAIL pre_reset: got d=%h st=%b want d=37 st=011", dout_a[0], state_a[0]);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (dout_a[0] !== 8'h00 || state_a[0] !== 3'b000 || ovf_a[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got d=%h st=%b ovf=%b want d=00 st=000 ovf=0", dout_a[0], state_a[0], ovf_a[0]);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (dout_a[0] !== 8'h01 || state_a[0] !== 3'b010) begin
         errors++;
         $display("[TB] FAIL post_reset: got d=%h st=%b want d=01 st=010", dout_a[0], state_a[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0) ^ (n >= 200), 8'($urandom));
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout_a[k] !== 8'(m_val[k]) || state_a[k] !== 3'(m_st[k]) || ovf_a[k] !== 1'(m_ovf[k])) begin
               errors++;
               $display("[TB] FAIL random cyc%0d dut%0d: got d=%h st=%b ovf=%b want d=%h st=%b ovf=%b",
                        n, k, dout_a[k], state_a[k], ovf_a[k], 8'(m_val[k]), 3'(m_st[k]), 1'(m_ovf[k]));
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin m_val[k] = 0; m_st[k] = 0; m_ovf[k] = 0; end
      test_reset();
      test_load_ff();
      test_wrap();
      test_saturate();
      test_step5();
      test_load_priority();
      test_direction_change();
      test_reset_mid_count();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cntr_n.md
CNTR_N -- requirements
Module: cntr_n

Interface
REQ-001 Parameter WIDTH, default 8: counter and data width in bits, legal range 2..32.
REQ-002 Parameter STEP, default 1: increment/decrement magnitude, legal range 1..2^WIDTH-1.
REQ-003 Parameter SAT, default 0: 0 selects wrap-around arithmetic; 1 selects saturating arithmetic.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 Port en, input, 1 bit: count enable.
REQ-007 Port load, input, 1 bit: parallel load request.
REQ-008 Port inc, input, 1 bit: direction select; 1 = up, 0 = down.
REQ-009 Port d_in, input, WIDTH bits: load data.
REQ-010 Port d_out, output, WIDTH bits: registered count value.
REQ-011 Port o_state, output, 3 bits: registered FSM state code.
REQ-012 Port ovf, output, 1 bit: registered one-cycle pulse on wrap or clamp.

Function
REQ-013 The FSM shall have these states: IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101; codes 110/111 are unused.
REQ-014 The next state shall be chosen by priority load > en:
- load=1 -> LOAD;
- else en=0 -> IDLE;
- else inc=1 -> INC2 if the current state is INC, otherwise INC;
- else inc=0 -> DEC2 if the current state is DEC, otherwise DEC.
REQ-015 INC/INC2 (and DEC/DEC2) shall alternate on every cycle that the same direction is held, so consecutive steps are visible on o_state.
REQ-016 From an unused state code, the FSM shall go to IDLE on the next edge and hold d_out.
REQ-017 d_out shall update on the same edge as the state transition, according to the next state:
- LOAD -> d_in;
- INC/INC2 -> d_out+STEP;
- DEC/DEC2 -> d_out-STEP;
- IDLE -> hold.
REQ-018 Latency shall be one cycle: inputs sampled at edge N appear on d_out and o_state after edge N.
REQ-019 With SAT=0, arithmetic shall be modulo 2^WIDTH; ovf=1 for one cycle when an increment carries out of, or a decrement borrows from, WIDTH bits.
REQ-020 With SAT=1, an increment whose exact result exceeds 2^WIDTH-1 shall set d_out to 2^WIDTH-1, and a decrement below 0 shall set d_out to 0; ovf=1 for that cycle.
REQ-021 With SAT=1, stepping while already at the limit shall keep d_out at the limit, and ovf shall stay 1 for every such cycle.
REQ-022 ovf shall be 0 in LOAD and IDLE cycles and on any in-range step.
REQ-023 load=1 together with en=1 shall load d_in; no step is applied in that cycle.
REQ-024 A direction change mid-count (INC2 -> DEC) shall take effect on the next edge without an intermediate IDLE cycle.

Reset
REQ-025 When reset=1 at a rising edge, d_out shall become 0, o_state IDLE (000) and ovf 0, regardless of en, load or inc.
REQ-026 Reset shall take priority over all other inputs, including mid-count and during LOAD.
REQ-027 The first edge with reset=0 shall evaluate REQ-014 from IDLE.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-028 Reset, then load=1 with d_in=0xFF for one cycle -> d_out=0xFF, o_state=001, ovf=0.
REQ-029 From d_out=0xFE with SAT=0, en=1, inc=1 for 3 cycles:
- d_out sequence 0xFF, 0x00, 0x01;
- o_state sequence 010, 011, 010;
- ovf=1 only on the 0x00 cycle.
REQ-030 SAT=1, from d_out=0x01, en=1, inc=0 for 3 cycles:
- d_out sequence 0x00, 0x00, 0x00;
- o_state sequence 100, 101, 100;
- ovf sequence 0, 1, 1.
REQ-031 STEP=5, SAT=0, from d_out=0xFD, one increment -> d_out=0x02 and ovf=1.
REQ-032 load=1, en=1, inc=1, d_in=0x40 in one cycle -> d_out=0x40, o_state=001; en=0 next cycle -> d_out holds 0x40, o_state=000.
REQ-033 reset=1 asserted while counting at d_out=0x37 in INC2 -> after the next edge d_out=0x00, o_state=000, ovf=0; counting resumes from 0x00 once reset=0.
